// File: rtl/conv_stream_bridge_pkg.sv
// Shared definitions for the conv stream bridge: FSM encoding, BRAM word
// geometry and the pixel-to-byte-address rule the conv core also uses.
package conv_stream_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int          PIX_W      = 8;
    localparam int          FIFO_DEPTH = 4;

    // One pixel per 32-bit BRAM word, byte addressed.
    function automatic logic [31:0] pix_addr(input logic [31:0] idx);
        return idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when the
// head is popped in the same cycle, so occupancy never exceeds DEPTH.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_stream_bridge.sv
// Streams a raster frame into BRAM0, kicks the conv core, then streams the
// BRAM1 result back out through a prefetch FIFO.
module conv_stream_bridge
    import conv_stream_bridge_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [31:0] bram0_addr,
    output logic [31:0] bram0_din,
    output logic [3:0]  bram0_we,
    output logic [31:0] bram1_addr,
    input  logic [31:0] bram1_dout,
    output logic        bram1_en,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        busy,
    output logic        error
);

    localparam int             N    = IMG_WIDTH * IMG_HEIGHT;
    localparam int             CW   = $clog2(N + 1);
    localparam int             FCW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);
    localparam logic [CW-1:0]  NCNT = CW'(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   p_q, p_d, q_q, q_d, o_q, o_d;
    logic            err_q, err_d, start_q, start_d;
    logic [31:0]     wa_q, wa_d, wd_q, wd_d;
    logic [3:0]      we_q, we_d;
    logic            rd_vld_q;
    logic            beat, issue, pop;
    logic            fifo_empty, fifo_full;
    logic [FCW-1:0]  fifo_cnt;
    logic [PIX_W-1:0] fifo_dout;
    logic            unused_hi;

    assign s_tready  = rst_n && (state_q == IDLE || state_q == LOAD);
    assign beat      = s_tvalid && s_tready;
    assign m_tvalid  = !fifo_empty;
    assign m_tdata   = fifo_dout;
    assign m_tlast   = m_tvalid && (o_q == LAST);
    assign pop       = m_tvalid && m_tready;
    // Reads in flight count against FIFO space so a returning word always fits.
    assign issue     = (state_q == DRAIN) && (q_q != NCNT) &&
                       ((fifo_cnt + FCW'(rd_vld_q)) < FCW'(FIFO_DEPTH));
    assign bram1_en   = issue;
    assign bram1_addr = pix_addr(32'(q_q));
    assign bram0_addr = wa_q;
    assign bram0_din  = wd_q;
    assign bram0_we   = we_q;
    assign conv_start = start_q;
    assign busy       = (state_q != IDLE);
    assign error      = err_q;
    assign unused_hi  = ^bram1_dout[31:8];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        o_d     = o_q;
        err_d   = err_q;
        start_d = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        we_d    = 4'b0000;
        case (state_q)
            IDLE, LOAD: begin
                if (beat) begin
                    if (state_q == IDLE) err_d = 1'b0;
                    if (s_tlast && p_q != LAST) begin
                        // Short frame: drop the beat and wait for a fresh one.
                        err_d   = 1'b1;
                        p_d     = '0;
                        state_d = IDLE;
                    end else begin
                        wa_d = pix_addr(32'(p_q));
                        wd_d = {24'd0, s_tdata};
                        we_d = 4'b1111;
                        if (p_q == LAST) begin
                            if (!s_tlast) err_d = 1'b1;
                            p_d     = '0;
                            state_d = RUN;
                        end else begin
                            p_d     = p_q + CW'(1);
                            state_d = LOAD;
                        end
                    end
                end
            end
            RUN: begin
                if (start_q && conv_done) state_d = DRAIN;
                else                      start_d = 1'b1;
            end
            DRAIN: begin
                if (issue) q_d = q_q + CW'(1);
                if (pop) begin
                    if (o_q == LAST) begin
                        o_d     = '0;
                        q_d     = '0;
                        state_d = IDLE;
                    end else begin
                        o_d = o_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            p_q      <= '0;
            q_q      <= '0;
            o_q      <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            we_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            q_q      <= q_d;
            o_q      <= o_d;
            err_q    <= err_d;
            start_q  <= start_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            rd_vld_q <= issue;
        end
    end

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_vld_q),
        .din_i   (bram1_dout[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/conv_stream_bridge.md
CONV_STREAM_BRIDGE -- requirements
Module: conv_stream_bridge

Interface
REQ-001 Parameter IMG_WIDTH, default 256, image width in pixels.
REQ-002 Parameter IMG_HEIGHT, default 256, image height in pixels.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s_tdata  in  8  input pixel, raster order.
REQ-006 s_tvalid  in  1 / s_tready  out  1 / s_tlast  in  1  input stream handshake and end-of-frame marker.
REQ-007 m_tdata  out  8  output magnitude pixel.
REQ-008 m_tvalid  out  1 / m_tready  in  1 / m_tlast  out  1  output stream handshake and end-of-frame marker.
REQ-009 bram0_addr  out  32 / bram0_din  out  32 / bram0_we  out  4  BRAM0 write port (image source for conv).
REQ-010 bram1_addr  out  32 / bram1_dout  in  32 / bram1_en  out  1  BRAM1 read port (conv result), read latency 1 cycle.
REQ-011 conv_start  out  1 / conv_done  in  1  control of the convolution core.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 error  out  1  sticky framing-error flag.

Function
REQ-014 The FSM SHALL use the states IDLE, LOAD, RUN, DRAIN, with N = IMG_WIDTH*IMG_HEIGHT and pixel index p in 0..N-1.
REQ-015 IDLE->LOAD on the first accepted s_tvalid beat; that beat is stored as p=0.
REQ-016 LOAD: s_tready=1; each beat (s_tvalid&s_tready) SHALL register bram0_addr=4*p, bram0_din={24'd0,s_tdata}, bram0_we=4'b1111 for exactly one cycle; otherwise bram0_we=0.
REQ-017 In LOAD, s_tlast with p<N-1 SHALL set error, drop the beat (no write), and return to IDLE without asserting conv_start.
REQ-018 At p=N-1 the beat is written regardless of s_tlast; missing s_tlast SHALL set error; the FSM then enters RUN.
REQ-019 s_tready SHALL be 0 in RUN and DRAIN; in IDLE it SHALL be 1.
REQ-020 RUN: conv_start SHALL be held at 1 from the cycle after the final BRAM0 write until conv_done is sampled high, then drops to 0 in the same cycle that the FSM enters DRAIN.
REQ-021 DRAIN: bram1_addr=4*q for read index q; bram1_en=1 only in issuing cycles; bram1_dout[7:0] is captured one cycle after bram1_addr/bram1_en are presented.
REQ-022 Reads SHALL pass through a 4-entry prefetch FIFO; a read SHALL be issued only when (FIFO occupancy + reads in flight) < 4.
REQ-023 m_tvalid = FIFO not empty; m_tdata = FIFO head; the head pops on m_tvalid&m_tready; m_tdata SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tlast SHALL be 1 exactly on output pixel N-1.
REQ-025 Simultaneous push and pop on a full or empty FIFO SHALL preserve ordering and occupancy with no loss or duplication.
REQ-026 After the pixel N-1 handshake the FSM SHALL return to IDLE; error clears only on the next IDLE->LOAD transition.
REQ-027 With m_tready held at 1, throughput SHALL be one pixel per clock after the initial latency of 2 cycles.

Reset
REQ-028 rst_n low SHALL force state=IDLE and p=q=0, empty the FIFO, and set all outputs to 0, except s_tready=1 once reset is released.
REQ-029 Reset mid-frame SHALL abandon the frame; no further BRAM writes or reads and no conv_start until a new frame arrives.

Structure
REQ-030 A shared package SHALL hold the state encoding, the constant WORD_BYTES=4, and the pixel-to-byte-address rule used by conv and this block alike.
REQ-031 The prefetch FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH=8, DEPTH=4).

Verification (IMG_WIDTH=IMG_HEIGHT=4, N=16, conv model returns BRAM1[i]=i+100)
REQ-032 Send 16 beats 0..15 with tlast on beat 15 -> BRAM0 word i = i, conv_start rises once, error=0.
REQ-033 m_tready=1 -> m_tdata 100..115 on consecutive cycles, m_tlast only on 115, then busy=0.
REQ-034 m_tready toggling 1/0 randomly -> identical sequence with no drops or duplicates; m_tdata stable while stalled.
REQ-035 tlast on beat 7 -> error=1, 7 writes only, conv_start never asserted, returns to IDLE.
REQ-036 rst_n pulsed low during DRAIN after 5 outputs -> all outputs 0 immediately; a next full frame completes correctly with error=0.
